// File: rtl/mem_stage_sram_ctrl.sv
// MEM stage controller: 32-bit loads/stores as two half-word accesses on a 16-bit async SRAM.
// Optional address range check is enabled by defining MEM_ADDR_CHECK_EN.
module mem_stage_sram_ctrl #(
  parameter int SRAM_WAIT = 3,
  parameter int BASE_ADDR = 1024,
  parameter int ADDR_W    = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic [31:0]       alu_res,
  input  logic [31:0]       val_rm,
  output logic              ready,
  output logic [31:0]       data_mem,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq_o,
  output logic              sram_dq_oe,
  input  logic [15:0]       sram_dq_i,
  output logic              sram_we_n,
  output logic              addr_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LO   = 2'd1;
  localparam logic [1:0] S_HI   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LAST       = CNT_W'(SRAM_WAIT - 1);
  localparam logic [CNT_W-1:0] CNT_STROBE_END = CNT_W'(SRAM_WAIT - 2);
  localparam logic [31:0]      BASE           = 32'(BASE_ADDR);

  logic [1:0]        r_state;
  logic [1:0]        w_nextState;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_nextCnt;
  logic              r_write;
  logic [ADDR_W-2:0] r_widx;
  logic [15:0]       r_wdataHi;
  logic [15:0]       r_lo16;
  logic [31:0]       r_dataMem;
  logic [ADDR_W-1:0] r_sramAddr;
  logic [15:0]       r_dqO;
  logic              r_dqOe;
  logic              r_weN;

  logic              w_req;
  logic              w_lastCnt;
  logic              w_rangeErr;
  logic [31:0]       w_offset;
  logic [29:0]       w_widxFull;
  logic [ADDR_W-2:0] w_widx;
  logic              w_unused;

  assign w_req      = mem_r_en | mem_w_en;
  assign w_offset   = alu_res - BASE;
  assign w_widxFull = w_offset[31:2];
  assign w_widx     = w_widxFull[ADDR_W-2:0];
  assign w_lastCnt  = (r_cnt == CNT_LAST);
  assign w_unused   = ^{w_offset[1:0], w_widxFull};

`ifdef MEM_ADDR_CHECK_EN
  logic r_addrErr;

  assign w_rangeErr = (alu_res < BASE) || ((w_widxFull >> (ADDR_W - 1)) != '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_addrErr <= 1'b0;
    end else if (r_state == S_IDLE && w_req && w_rangeErr) begin
      r_addrErr <= 1'b1;
    end
  end

  assign addr_err = r_addrErr;
`else
  assign w_rangeErr = 1'b0;
  assign addr_err   = 1'b0;
`endif

  // DONE always returns to IDLE: the frozen pipeline still presents the finished request there.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_nextCnt   = '0;
          w_nextState = w_rangeErr ? S_DONE : S_LO;
        end
      end
      S_LO: begin
        if (w_lastCnt) begin
          w_nextState = S_HI;
          w_nextCnt   = '0;
        end else begin
          w_nextCnt = r_cnt + CNT_W'(1);
        end
      end
      S_HI: begin
        if (w_lastCnt) begin
          w_nextState = S_DONE;
          w_nextCnt   = '0;
        end else begin
          w_nextCnt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_nextState = S_IDLE;
        w_nextCnt   = '0;
      end
    endcase
  end

  // SRAM pins are registered from the state being entered; the strobe lifts on the last cycle of each half.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_write    <= 1'b0;
      r_widx     <= '0;
      r_wdataHi  <= '0;
      r_lo16     <= '0;
      r_dataMem  <= '0;
      r_sramAddr <= '0;
      r_dqO      <= '0;
      r_dqOe     <= 1'b0;
      r_weN      <= 1'b1;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_write   <= mem_w_en;
            r_widx    <= w_widx;
            r_wdataHi <= val_rm[31:16];
            if (w_rangeErr) begin
              if (!mem_w_en) begin
                r_dataMem <= '0;
              end
            end else begin
              r_sramAddr <= {w_widx, 1'b0};
              r_dqO      <= val_rm[15:0];
              r_dqOe     <= mem_w_en;
              r_weN      <= ~mem_w_en;
            end
          end
        end
        S_LO: begin
          if (w_lastCnt) begin
            r_lo16     <= sram_dq_i;
            r_sramAddr <= {r_widx, 1'b1};
            r_dqO      <= r_wdataHi;
            r_weN      <= ~r_write;
          end else begin
            r_weN <= ~(r_write && (w_nextCnt <= CNT_STROBE_END));
          end
        end
        S_HI: begin
          if (w_lastCnt) begin
            r_dqOe <= 1'b0;
            r_weN  <= 1'b1;
            if (!r_write) begin
              r_dataMem <= {sram_dq_i, r_lo16};
            end
          end else begin
            r_weN <= ~(r_write && (w_nextCnt <= CNT_STROBE_END));
          end
        end
        default: begin
          r_dqOe <= 1'b0;
          r_weN  <= 1'b1;
        end
      endcase
    end
  end

  assign ready      = ((r_state == S_IDLE) && !w_req) || (r_state == S_DONE);
  assign data_mem   = r_dataMem;
  assign sram_addr  = r_sramAddr;
  assign sram_dq_o  = r_dqO;
  assign sram_dq_oe = r_dqOe;
  assign sram_we_n  = r_weN;

endmodule
